// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment display path: active-low segment codes
// ({g,f,e,d,c,b,a}, 0 = lit) and the counter width helper.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h27;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // At least one bit, so a single-digit or single-cycle counter still has a register.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment code.
module seg7_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed common-anode hex display driver with frame-synchronous
// shadow/display registers, leading-zero blanking and per-digit decimal point.
module hex_display_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int unsigned PW = cnt_width(REFRESH_DIV);
    localparam int unsigned IW = cnt_width(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_CNT  = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
    logic                    shadow_blz_q, shadow_blz_d, disp_blz_q, disp_blz_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    logic                    tick, boundary, blank, run_zero;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   lead_zero;

    seg7_decode u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // lead_zero[k]: nibbles k..NUM_DIGITS-1 of the displayed value are all zero.
    always_comb begin
        cur_nib  = 4'h0;
        run_zero = 1'b1;
        lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run_zero     = run_zero & (disp_val_q[4*k +: 4] == 4'h0);
            lead_zero[k] = run_zero;
            if (idx_q == IW'(k)) begin
                cur_nib = disp_val_q[4*k +: 4];
            end
        end
        blank = disp_blz_q && lead_zero[idx_q] && (idx_q != '0);
    end

    always_comb begin
        tick     = en && (presc_q == PRESC_LAST);
        boundary = tick && (idx_q == IDX_LAST);

        presc_d = presc_q;
        idx_d   = idx_q;
        if (en) begin
            if (tick) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_blz_d = shadow_blz_q;
        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
            shadow_blz_d = blank_lz;
        end

        // A load on the boundary cycle bypasses the shadow and lands directly.
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        disp_blz_d = disp_blz_q;
        pending_d  = pending_q;
        if (boundary) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
                disp_blz_d = blank_lz;
            end else if (pending_q) begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
                disp_blz_d = shadow_blz_q;
            end
            pending_d = 1'b0;
        end else if (!en && pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
            disp_blz_d = shadow_blz_q;
            pending_d  = load;
        end else if (load) begin
            pending_d = 1'b1;
        end

        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        an_d  = '1;
        fd_d  = boundary;
        if (en) begin
            seg_d = blank ? SEG_OFF : dec_seg;
            dp_d  = ~disp_dp_q[idx_q];
            if (presc_q >= GUARD_CNT) begin
                an_d = ~(NUM_DIGITS'(1) << idx_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            shadow_blz_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blz_q   <= 1'b0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            an_q         <= '1;
            fd_q         <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_blz_q <= shadow_blz_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_blz_q   <= disp_blz_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            fd_q         <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux with a frame-position model checked every cycle.
module tb_hex_display_mux;

    localparam int ND   = 4;
    localparam int DIV  = 8;
    localparam int GRD  = 2;
    localparam int FLEN = ND * DIV;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;

    hex_display_mux #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV),
        .GUARD       (GRD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    int n_checks = 0;
    int n_errors = 0;

    // Model: m_t is the position within the frame in clock cycles.
    int          m_t;
    int          rendered;
    logic [15:0] m_sh_val, m_dsp_val;
    logic [3:0]  m_sh_dp, m_dsp_dp;
    logic        m_sh_blz, m_dsp_blz, m_pend;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;
    logic [3:0]  exp_an;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input logic [15:0] v, input logic blz, input int k);
        bit all_zero;
        logic [3:0] nib;
        all_zero = 1'b1;
        for (int j = k; j < ND; j++) begin
            if (v[j*4 +: 4] != 4'h0) all_zero = 1'b0;
        end
        if (blz && k != 0 && all_zero) return 7'h7F;
        nib = v[k*4 +: 4];
        return TBL[nib];
    endfunction

    // One clock: advance the model with the inputs seen at this edge, then compare at negedge.
    task automatic step();
        int slot;
        int ph;
        bit bnd;
        logic [15:0] o_val;
        logic [3:0]  o_dp;
        logic        o_blz;
        slot = m_t / DIV;
        ph   = m_t % DIV;
        if (!rst_n) begin
            m_t = 0; m_pend = 0;
            m_sh_val = '0; m_sh_dp = '0; m_sh_blz = 0;
            m_dsp_val = '0; m_dsp_dp = '0; m_dsp_blz = 0;
            exp_seg = 7'h7F; exp_dp = 1; exp_an = 4'hF; exp_fd = 0;
            rendered = -1;
        end else begin
            exp_seg  = en ? model_seg(m_dsp_val, m_dsp_blz, slot) : 7'h7F;
            exp_dp   = en ? ~m_dsp_dp[slot] : 1'b1;
            exp_an   = (en && ph >= GRD) ? ~(4'b0001 << slot) : 4'hF;
            bnd      = en && (m_t == FLEN - 1);
            exp_fd   = bnd;
            rendered = en ? m_t : -1;
            o_val = m_sh_val; o_dp = m_sh_dp; o_blz = m_sh_blz;
            if (load) begin
                m_sh_val = value; m_sh_dp = dp_in; m_sh_blz = blank_lz;
            end
            if (bnd) begin
                if (load) begin
                    m_dsp_val = value; m_dsp_dp = dp_in; m_dsp_blz = blank_lz;
                end else if (m_pend) begin
                    m_dsp_val = o_val; m_dsp_dp = o_dp; m_dsp_blz = o_blz;
                end
                m_pend = 0;
            end else if (!en && m_pend) begin
                m_dsp_val = o_val; m_dsp_dp = o_dp; m_dsp_blz = o_blz;
                m_pend = load;
            end else if (load) begin
                m_pend = 1;
            end
            if (en) m_t = (m_t + 1) % FLEN;
        end
        @(posedge clk);
        @(negedge clk);
        chk("seg", {25'd0, seg}, {25'd0, exp_seg});
        chk("dp", {31'd0, dp}, {31'd0, exp_dp});
        chk("an", {28'd0, an}, {28'd0, exp_an});
        chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    endtask

    task automatic run_state(input int target);
        bit found;
        found = (m_t == target);
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = (m_t == target);
        end
        chk("reach_state", {31'd0, found}, 32'd1);
    endtask

    task automatic run_render(input int target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = (rendered == target);
        end
        chk("reach_render", {31'd0, found}, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        value = v; dp_in = d; blank_lz = b; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n = 0; en = 0; load = 0; value = '0; dp_in = '0; blank_lz = 0;
        m_t = 0; rendered = -1;
        @(negedge clk);
        step();
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        rst_n = 1;
        en = 1;

        // 1: scan order and guard cycles with zero display
        run_render(0);  chk("t1_guard0", {28'd0, an}, 32'hF);
        run_render(1);  chk("t1_guard1", {28'd0, an}, 32'hF);
        run_render(2);  chk("t1_an0", {28'd0, an}, 32'hE);
        chk("t1_seg0", {25'd0, seg}, 32'h40);
        run_render(10); chk("t1_an1", {28'd0, an}, 32'hD);
        run_render(18); chk("t1_an2", {28'd0, an}, 32'hB);
        run_render(26); chk("t1_an3", {28'd0, an}, 32'h7);
        chk("t1_seg3", {25'd0, seg}, 32'h40);

        // 2: mid-frame load waits for the boundary
        run_state(12);
        do_load(16'h12AF, 4'h0, 1'b0);
        run_render(18); chk("t2_hold", {25'd0, seg}, 32'h40);
        run_render(31); chk("t2_fd", {31'd0, frame_done}, 32'd1);
        run_render(2);  chk("t2_d0", {25'd0, seg}, 32'h0E);
        run_render(10); chk("t2_d1", {25'd0, seg}, 32'h08);
        run_render(18); chk("t2_d2", {25'd0, seg}, 32'h24);
        run_render(26); chk("t2_d3", {25'd0, seg}, 32'h79);

        // 3: leading-zero blanking
        do_load(16'h0050, 4'h0, 1'b1);
        run_render(31);
        run_render(2);  chk("t3_d0", {25'd0, seg}, 32'h40);
        run_render(10); chk("t3_d1", {25'd0, seg}, 32'h12);
        run_render(18); chk("t3_d2", {25'd0, seg}, 32'h7F);
        run_render(26); chk("t3_d3", {25'd0, seg}, 32'h7F);
        do_load(16'h0000, 4'h0, 1'b1);
        run_render(31);
        run_render(2);  chk("t3z_d0", {25'd0, seg}, 32'h40);
        run_render(10); chk("t3z_d1", {25'd0, seg}, 32'h7F);

        // 4: last load wins, second one on the boundary cycle
        run_state(5);
        do_load(16'h1111, 4'h0, 1'b0);
        run_state(FLEN - 1);
        do_load(16'h2222, 4'h0, 1'b0);
        chk("t4_fd", {31'd0, frame_done}, 32'd1);
        run_render(2);  chk("t4_d0", {25'd0, seg}, 32'h24);
        run_render(18); chk("t4_d2", {25'd0, seg}, 32'h24);

        // 5: pause mid-slot 2, load dp while paused, resume
        run_state(19);
        en = 0;
        do_load(16'h2222, 4'b0101, 1'b0);
        for (int i = 0; i < 19; i++) begin
            step();
            chk("t5_an_off", {28'd0, an}, 32'hF);
            chk("t5_seg_off", {25'd0, seg}, 32'h7F);
        end
        en = 1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!frame_done && cnt < 40);
        chk("t5_resume_len", cnt, 32'd13);
        run_render(2);  chk("t5_dp0", {31'd0, dp}, 32'd0);
        run_render(10); chk("t5_dp1", {31'd0, dp}, 32'd1);
        run_render(18); chk("t5_dp2", {31'd0, dp}, 32'd0);
        run_render(26); chk("t5_dp3", {31'd0, dp}, 32'd1);

        // 6: reset mid-slot 3
        run_state(28);
        rst_n = 0;
        step();
        chk("t6_seg", {25'd0, seg}, 32'h7F);
        chk("t6_an", {28'd0, an}, 32'hF);
        chk("t6_fd", {31'd0, frame_done}, 32'd0);
        rst_n = 1;
        step(); step(); step();
        chk("t6_an0", {28'd0, an}, 32'hE);
        chk("t6_seg0", {25'd0, seg}, 32'h40);
        chk("t6_dp0", {31'd0, dp}, 32'd1);
        run_render(31);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
